// File: rtl/serpent_decrypt_iter.sv
// Iterative Serpent block decryption, UNROLL inverse rounds per clock.
// Ports: i_clk/i_rst_n; ciphertext words in with i_valid/o_ready; 33 round
// keys (K_n at [128n+127:128n]); plaintext words out with o_valid/i_ready;
// o_busy while rounds run.
module serpent_decrypt_iter #(
  parameter int UNROLL = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [31:0]         i_data_word_0,
  input  logic [31:0]         i_data_word_1,
  input  logic [31:0]         i_data_word_2,
  input  logic [31:0]         i_data_word_3,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [33*128-1:0]   i_round_keys,
  output logic [31:0]         o_data_word_0,
  output logic [31:0]         o_data_word_1,
  output logic [31:0]         o_data_word_2,
  output logic [31:0]         o_data_word_3,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_busy
);

  if (!(UNROLL == 1 || UNROLL == 2 ||
        UNROLL == 4 || UNROLL == 8)) begin : g_bad_unroll
    $error("serpent_decrypt_iter: UNROLL must be 1, 2, 4 or 8");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam logic [4:0] STEP = 5'(UNROLL);

  // Inverse S-boxes 0..7; entry [s][n] is InvS_s(n).
  localparam logic [0:7][0:15][3:0] INV_SBOX = {
    64'hD3B0A65C1E47F982,
    64'h582EF6C3B4791DA0,
    64'hC9F4BE12036D58A7,
    64'h09A7BE6D35C248F1,
    64'h5083A97E2CB64FD1,
    64'h8F2941DEB6537CA0,
    64'hFA1D536049E72C8B,
    64'h306D9EF85CB7A142
  };

  function automatic logic [31:0] ror(
    input logic [31:0] x,
    input int          n
  );
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [127:0] inv_lt(
    input logic [127:0] b
  );
    logic [31:0] x0, x1, x2, x3;
    {x3, x2, x1, x0} = b;
    x2 = ror(x2, 22);
    x0 = ror(x0, 5);
    x2 = x2 ^ x3 ^ (x1 << 7);
    x0 = x0 ^ x1 ^ x3;
    x3 = ror(x3, 7);
    x1 = ror(x1, 1);
    x3 = x3 ^ x2 ^ (x0 << 3);
    x1 = x1 ^ x0 ^ x2;
    x2 = ror(x2, 3);
    x0 = ror(x0, 13);
    return {x3, x2, x1, x0};
  endfunction

  // Bitslice: nibble j is {w3[j], w2[j], w1[j], w0[j]}.
  function automatic logic [127:0] inv_sbox(
    input logic [2:0]   s,
    input logic [127:0] b
  );
    logic [127:0] y;
    logic [3:0]   n;
    logic [3:0]   o;
    y = '0;
    for (int j = 0; j < 32; j++) begin
      n = {b[96+j], b[64+j], b[32+j], b[j]};
      o = INV_SBOX[s][n];
      y[j]    = o[0];
      y[32+j] = o[1];
      y[64+j] = o[2];
      y[96+j] = o[3];
    end
    return y;
  endfunction

  function automatic logic [127:0] inv_round(
    input logic [127:0] x,
    input logic [4:0]   r,
    input logic [127:0] k32,
    input logic [127:0] kr
  );
    logic [127:0] t;
    t = (r == 5'd31) ? (x ^ k32) : inv_lt(x);
    t = inv_sbox(r[2:0], t);
    return t ^ kr;
  endfunction

  state_e             state_q, state_d;
  logic [127:0]       blk_q, blk_d;
  logic [4:0]         rnd_q, rnd_d;
  logic [32:0][127:0] keys;
  logic [127:0]       chain;
  logic [4:0]         rr;

  assign keys = i_round_keys;

  // UNROLL rounds r, r-1, ... chained in one cycle.
  always_comb begin
    chain = blk_q;
    rr    = rnd_q;
    for (int u = 0; u < UNROLL; u++) begin
      rr    = rnd_q - 5'(u);
      chain = inv_round(chain, rr, keys[32],
                        keys[{1'b0, rr}]);
    end
  end

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    rnd_d   = rnd_q;
    unique case (state_q)
      IDLE: begin
        if (i_valid) begin
          blk_d   = {i_data_word_3, i_data_word_2,
                     i_data_word_1, i_data_word_0};
          rnd_d   = 5'd31;
          state_d = BUSY;
        end
      end
      BUSY: begin
        blk_d = chain;
        // Last pass covers round 0: park counter instead of wrapping.
        if (rnd_q == STEP - 5'd1) begin
          rnd_d   = 5'd31;
          state_d = DONE;
        end else begin
          rnd_d = rnd_q - STEP;
        end
      end
      DONE: begin
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      blk_q   <= '0;
      rnd_q   <= 5'd31;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      rnd_q   <= rnd_d;
    end
  end

  assign o_ready = (state_q == IDLE);
  assign o_busy  = (state_q == BUSY);
  assign o_valid = (state_q == DONE);

  assign o_data_word_0 = blk_q[31:0];
  assign o_data_word_1 = blk_q[63:32];
  assign o_data_word_2 = blk_q[95:64];
  assign o_data_word_3 = blk_q[127:96];

endmodule

// File: tb/tb_serpent_decrypt_iter.sv
// Scoreboard bench for serpent_decrypt_iter, UNROLL = 1, 2, 4, 8 in parallel.
// Ciphertext comes from a forward Serpent model; plaintext is the expectation.
module tb_serpent_decrypt_iter;

  localparam logic [127:0] KNOWN_PT =
    128'h00112233_44556677_8899AABB_CCDDEEFF;

  // Forward S-boxes 0..7; entry [s][n] is S_s(n).
  localparam logic [0:7][0:15][3:0] SB = {
    64'h38F1A65BED42709C,
    64'hFC27905A1BE86D34,
    64'h86793CAFD1E40B52,
    64'h0FB8C963D124A75E,
    64'h1F83C0B6254A9E7D,
    64'hF52B4A9C03E8D671,
    64'h72C5846BE91FD3A0,
    64'h1DF0E82B74CA9356
  };

  logic               clk = 1'b0;
  logic               rst_n;
  logic [127:0]       din;
  logic               i_valid;
  logic               i_ready;
  logic [32:0][127:0] keys;
  logic [3:0]         rdy, vld, bsy;
  logic [127:0]       dout [4];
  bit                 rand_rdy;

  int checks = 0;
  int errors = 0;

  logic [127:0] expq [4][$];
  int           busy_cnt [4];
  bit           pv [4];
  bit           hs [4];
  logic [127:0] held [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    logic [31:0] w0, w1, w2, w3;
    serpent_decrypt_iter #(.UNROLL(1 << g)) u_dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_data_word_0 (din[31:0]),
      .i_data_word_1 (din[63:32]),
      .i_data_word_2 (din[95:64]),
      .i_data_word_3 (din[127:96]),
      .i_valid       (i_valid),
      .o_ready       (rdy[g]),
      .i_round_keys  (keys),
      .o_data_word_0 (w0),
      .o_data_word_1 (w1),
      .o_data_word_2 (w2),
      .o_data_word_3 (w3),
      .o_valid       (vld[g]),
      .i_ready       (i_ready),
      .o_busy        (bsy[g])
    );
    assign dout[g] = {w3, w2, w1, w0};
  end

  task automatic chk(input string nm, input int k,
                     input logic [127:0] act,
                     input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s dut%0d actual %h required %h",
               nm, k, act, req);
    end
  endtask

  function automatic logic [31:0] rl(input logic [31:0] x,
                                     input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [127:0] lt_fwd(input logic [127:0] b);
    logic [31:0] x0, x1, x2, x3;
    {x3, x2, x1, x0} = b;
    x0 = rl(x0, 13);
    x2 = rl(x2, 3);
    x1 = x1 ^ x0 ^ x2;
    x3 = x3 ^ x2 ^ (x0 << 3);
    x1 = rl(x1, 1);
    x3 = rl(x3, 7);
    x0 = x0 ^ x1 ^ x3;
    x2 = x2 ^ x3 ^ (x1 << 7);
    x0 = rl(x0, 5);
    x2 = rl(x2, 22);
    return {x3, x2, x1, x0};
  endfunction

  function automatic logic [127:0] lt_inv(input logic [127:0] b);
    logic [31:0] x0, x1, x2, x3;
    {x3, x2, x1, x0} = b;
    x2 = rl(x2, 10);
    x0 = rl(x0, 27);
    x2 = x2 ^ x3 ^ (x1 << 7);
    x0 = x0 ^ x1 ^ x3;
    x3 = rl(x3, 25);
    x1 = rl(x1, 31);
    x3 = x3 ^ x2 ^ (x0 << 3);
    x1 = x1 ^ x0 ^ x2;
    x2 = rl(x2, 29);
    x0 = rl(x0, 19);
    return {x3, x2, x1, x0};
  endfunction

  // Inverse is found by searching the forward table.
  function automatic logic [127:0] sb(input int s,
                                      input logic [127:0] x,
                                      input bit inv);
    logic [127:0] y;
    logic [3:0]   n, o;
    y = '0;
    for (int j = 0; j < 32; j++) begin
      n = {x[96+j], x[64+j], x[32+j], x[j]};
      o = '0;
      if (!inv) o = SB[s[2:0]][n];
      else
        for (int v = 0; v < 16; v++)
          if (SB[s[2:0]][v[3:0]] == n) o = v[3:0];
      y[j]    = o[0];
      y[32+j] = o[1];
      y[64+j] = o[2];
      y[96+j] = o[3];
    end
    return y;
  endfunction

  function automatic logic [127:0] enc(input logic [127:0] p,
                                       input logic [32:0][127:0] k);
    logic [127:0] x;
    x = p;
    for (int i = 0; i < 32; i++) begin
      x = sb(i % 8, x ^ k[i], 1'b0);
      if (i < 31) x = lt_fwd(x);
      else        x = x ^ k[32];
    end
    return x;
  endfunction

  function automatic logic [127:0] dec(input logic [127:0] c,
                                       input logic [32:0][127:0] k);
    logic [127:0] x;
    x = c;
    for (int r = 31; r >= 0; r--) begin
      if (r == 31) x = x ^ k[32];
      else         x = lt_inv(x);
      x = sb(r % 8, x, 1'b1) ^ k[r];
    end
    return x;
  endfunction

  function automatic logic [32:0][127:0] rand_keys();
    logic [32:0][127:0] k;
    for (int i = 0; i < 33; i++)
      for (int w = 0; w < 4; w++)
        k[i][32*w +: 32] = $urandom;
    return k;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: pops expected plaintext on every output handshake.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (!rst_n) begin
        busy_cnt[k] = 0;
        pv[k] = 0;
        hs[k] = 0;
        expq[k].delete();
      end else begin
        if (hs[k]) chk("idle_after_accept", k,
                       128'({rdy[k], vld[k]}), 128'(2'b10));
        hs[k] = 0;
        if (bsy[k]) busy_cnt[k]++;
        if (vld[k]) begin
          if (!pv[k]) begin
            chk("busy_cycles", k, 128'(busy_cnt[k]),
                128'(32 >> k));
            busy_cnt[k] = 0;
            held[k] = dout[k];
          end else begin
            chk("hold_data", k, dout[k], held[k]);
          end
          chk("ready_low_done", k, 128'(rdy[k]), 128'(0));
          if (i_ready) begin
            if (expq[k].size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_output dut%0d actual %h required none",
                       k, dout[k]);
            end else begin
              chk("plaintext", k, dout[k], expq[k].pop_front());
            end
            hs[k] = 1;
          end
          pv[k] = !i_ready;
        end else begin
          pv[k] = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) i_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!(&rdy) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!(&rdy)) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual %b required 1111", rdy);
    end
  endtask

  // Issue one block; expected plaintext goes to every scoreboard.
  task automatic send(input logic [127:0] c,
                      input logic [127:0] p);
    wait_ready();
    din = c;
    i_valid = 1'b1;
    for (int k = 0; k < 4; k++) expq[k].push_back(p);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((expq[0].size() + expq[1].size() + expq[2].size() +
            expq[3].size() != 0 || !(&rdy)) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual %0d required 0",
               expq[0].size());
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    for (int k = 0; k < 4; k++) begin
      chk({nm, "_ready"}, k, 128'(rdy[k]), 128'(1));
      chk({nm, "_valid"}, k, 128'(vld[k]), 128'(0));
      chk({nm, "_busy"}, k, 128'(bsy[k]), 128'(0));
      chk({nm, "_data"}, k, dout[k], 128'(0));
    end
  endtask

  initial begin
    logic [127:0] p;
    int n;
    rst_n = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    din = '0;
    keys = '0;
    rand_rdy = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // Known vector; data/valid wiggles while busy must be ignored.
    keys = rand_keys();
    send(enc(KNOWN_PT, keys), KNOWN_PT);
    for (int i = 0; i < 3; i++) begin
      din = rand128();
      i_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
    drain();

    // All-zero keys and ciphertext.
    keys = '0;
    send(128'(0), dec(128'(0), keys));
    drain();

    // Backpressure in DONE with stray i_valid pulses.
    i_ready = 1'b0;
    keys = rand_keys();
    p = rand128();
    send(enc(p, keys), p);
    n = 0;
    while (!(&vld) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("all_done", 0, 128'(vld), 128'(4'hF));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      i_valid = i[0];
      din = rand128();
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    drain();

    // Reset on the 10th busy cycle, then decrypt afresh.
    i_ready = 1'b0;
    keys = rand_keys();
    p = rand128();
    send(enc(p, keys), p);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_outputs("midop_reset");
    rst_n = 1'b1;
    i_ready = 1'b1;
    send(enc(KNOWN_PT, keys), KNOWN_PT);
    drain();

    // Random traffic with random gaps and backpressure.
    rand_rdy = 1;
    for (int b = 0; b < 1000; b++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      wait_ready();
      keys = rand_keys();
      p = rand128();
      send(enc(p, keys), p);
    end
    drain();
    rand_rdy = 0;
    i_ready = 1'b1;
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serpent_decrypt_iter.md
SERPENT_DECRYPT_ITER -- requirements
Module: serpent_decrypt_iter

Interface
REQ-001 SHALL have parameter UNROLL, default 1; decryption rounds applied per clock; legal values 1, 2, 4, 8.
REQ-002 SHALL have port i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst_n, input, 1, synchronous active-low reset, sampled on the i_clk rising edge.
REQ-004 SHALL have ports i_data_word_0..i_data_word_3, input, 32 each, ciphertext in bitslice word order.
REQ-005 SHALL have port i_valid, input, 1, ciphertext present.
REQ-006 SHALL have port o_ready, output, 1, block can accept ciphertext.
REQ-007 SHALL have port i_round_keys, input, 33*128, key K_n in bits [128n+127:128n], K_n word w in bits [128n+32w+31:128n+32w].
REQ-008 SHALL have ports o_data_word_0..o_data_word_3, output, 32 each, plaintext.
REQ-009 SHALL have port o_valid, output, 1, plaintext present.
REQ-010 SHALL have port i_ready, input, 1, consumer accepts plaintext.
REQ-011 SHALL have port o_busy, output, 1, high while rounds are in progress.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY and DONE; o_ready = (state==IDLE), o_busy = (state==BUSY), o_valid = (state==DONE).
REQ-013 IDLE with i_valid=1 at an edge SHALL load the data words into the state register, set round counter r=31 and go to BUSY; i_valid=0 SHALL leave IDLE unchanged.
REQ-014 Round r SHALL be, in order: if r==31, XOR with K_32; else apply inverse linear transform; then inverse S-box index (r mod 8); then XOR with K_r.
REQ-015 Each BUSY edge SHALL apply UNROLL consecutive rounds r, r-1, ..., r-UNROLL+1 combinationally and register the result; r SHALL decrement by UNROLL.
REQ-016 The BUSY edge that applies round 0 SHALL go to DONE; BUSY SHALL last exactly 32/UNROLL cycles.
REQ-017 Latency: acceptance at edge E0 -> o_valid high after edge E0+32/UNROLL (UNROLL=1: 32; UNROLL=8: 4).
REQ-018 The round counter SHALL be 5 bits; it never underflows, because 32 mod UNROLL == 0 and DONE is entered instead of wrapping.
REQ-019 In DONE the o_data words SHALL stay stable until an edge with i_ready=1, which SHALL go to IDLE; i_valid in DONE SHALL be ignored.
REQ-020 o_data words SHALL always reflect the state register; their value outside DONE has no meaning.
REQ-021 i_round_keys SHALL be held stable by the user from acceptance until o_valid; the block does not capture keys.
REQ-022 i_valid, i_ready and i_data changes during BUSY SHALL have no effect.
REQ-023 An unsupported UNROLL SHALL stop elaboration (generate-time error).

Reset
REQ-024 i_rst_n=0 at an edge SHALL force state IDLE, r=31, state register 0; it overrides all other inputs.
REQ-025 After reset the outputs SHALL be: o_ready=1, o_valid=0, o_busy=0, o_data words 0.
REQ-026 Reset in BUSY or DONE SHALL abandon the block without producing output; the next acceptance SHALL decrypt from scratch.

Verification
REQ-027 UNROLL=1, random key schedule, ciphertext = reference-model encryption of plaintext 0x00112233_44556677_8899AABB_CCDDEEFF -> that plaintext after 32 cycles; o_valid first high exactly 32 edges after acceptance.
REQ-028 UNROLL=1, 2, 4 and 8, same vector -> identical plaintext; o_busy high for 32, 16, 8 and 4 cycles respectively.
REQ-029 Backpressure: hold i_ready=0 for 10 cycles in DONE -> o_valid and data stable, o_ready=0, extra i_valid pulses ignored; i_ready=1 -> IDLE next edge.
REQ-030 Reset mid-operation: i_rst_n=0 on the 10th BUSY cycle -> next cycle o_ready=1, o_valid=0, data 0; a new block then decrypts correctly.
REQ-031 Back-to-back: 1000 random key/ciphertext pairs with random i_valid/i_ready gaps -> every output matches the model, in order, none dropped or duplicated.
REQ-032 All-zero key schedule and all-zero ciphertext -> output equals the model's decryption; checks S-box index selection (r mod 8) at every round.
